// File: rtl/arq_rx_fsm_pkg.sv
// ----------------------------------------------------------------------------
// arq_pkg
// Items shared by the stop-and-wait ARQ receiver, its FIFO and the matching
// transmitter:
//   ARQ_DATA_WIDTH : default payload width, common to tx and rx
//   arq_state_e    : receiver FSM states (IDLE, CHECK, RESP)
//   even_parity()  : even parity bit over {data, seq}
// ----------------------------------------------------------------------------
package arq_pkg;

    localparam int ARQ_DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } arq_state_e;

    // Data is passed zero-extended to 32 bits. Zero padding does not change
    // the XOR, so callers of any width up to 32 bits can share this function.
    function automatic logic even_parity(input logic [31:0] data, input logic seq);
        return ^{data, seq};
    endfunction

endpackage

// File: rtl/arq_rx_fsm_if.sv
// ----------------------------------------------------------------------------
// arq_rx_fsm_if
// Frame and response channel between an ARQ transmitter and arq_rx_fsm.
//   frame_valid/data/seq/parity : frame offered by the transmitter
//   ack/nack/resp_seq           : one-cycle response from the receiver
//   rx_busy                     : receiver is processing a frame
// Modports: master = transmitter side, slave = receiver side.
// ----------------------------------------------------------------------------
interface arq_rx_fsm_if
    import arq_pkg::*;
#(
    parameter int DATA_WIDTH = ARQ_DATA_WIDTH
);
    logic                  frame_valid;
    logic [DATA_WIDTH-1:0] frame_data;
    logic                  frame_seq;
    logic                  frame_parity;
    logic                  ack;
    logic                  nack;
    logic                  resp_seq;
    logic                  rx_busy;

    modport master (
        output frame_valid, frame_data, frame_seq, frame_parity,
        input  ack, nack, resp_seq, rx_busy
    );

    modport slave (
        input  frame_valid, frame_data, frame_seq, frame_parity,
        output ack, nack, resp_seq, rx_busy
    );
endinterface

// File: rtl/arq_rx_fsm_fifo.sv
// ----------------------------------------------------------------------------
// arq_rx_fifo
// Synchronous first-word-fall-through FIFO. Synchronous active-low reset
// clears the pointers, the count and the storage.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   push_i     : write data_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   data_i     : write data
//   data_o     : head entry, 0 when empty
//   empty_o    : no entries stored
//   full_o     : DEPTH entries stored
// ----------------------------------------------------------------------------
module arq_rx_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap on their own because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/arq_rx_fsm.sv
// ----------------------------------------------------------------------------
// arq_rx_fsm
// Receiver end of a stop-and-wait ARQ link. The receiver handles one frame
// at a time. It checks the even parity and the alternating sequence bit,
// answers with a one-cycle ack or nack, drops duplicates, and writes
// in-order payloads into a FWFT receive FIFO.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   link (slave)  : frame input, ack/nack/resp_seq response, rx_busy
//   rd_en_i       : consumer pop request
//   data_out_o    : FIFO head, 0 when empty
//   empty_o       : FIFO empty
//   full_o        : FIFO full
//   err_count_o   : saturating count of parity nacks
//   dup_count_o   : saturating count of duplicate frames that were acked
//                   (present only when ARQ_RX_STATS_EN is defined)
// Optional feature macro: ARQ_RX_STATS_EN
// ----------------------------------------------------------------------------
module arq_rx_fsm
    import arq_pkg::*;
#(
    parameter int DATA_WIDTH    = ARQ_DATA_WIDTH,
    parameter int FIFO_DEPTH    = 4,
    parameter int ERR_CNT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    arq_rx_fsm_if.slave              link,
    input  logic                     rd_en_i,
    output logic [DATA_WIDTH-1:0]    data_out_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o
`ifdef ARQ_RX_STATS_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0] dup_count_o
`endif
);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    arq_state_e              state_q, state_d;
    logic                    exp_seq_q, exp_seq_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    seq_q, seq_d;
    logic                    par_q, par_d;
    logic                    ack_q, ack_d;
    logic                    nack_q, nack_d;
    logic                    resp_seq_q, resp_seq_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
`ifdef ARQ_RX_STATS_EN
    logic [ERR_CNT_WIDTH-1:0] dup_q, dup_d;
`endif
    logic                    push;
    logic                    parity_ok;

    assign parity_ok = (even_parity(32'(data_q), seq_q) == par_q);

    // The response registers are the outputs. This makes ack/nack last
    // exactly the RESP cycle.
    assign link.ack      = ack_q;
    assign link.nack     = nack_q;
    assign link.resp_seq = resp_seq_q;
    assign link.rx_busy  = (state_q != IDLE);
    assign err_count_o   = err_q;
`ifdef ARQ_RX_STATS_EN
    assign dup_count_o   = dup_q;
`endif

    // State and captured frame. Reset can abort a frame at any point. The
    // response registers clear on reset, so the aborted frame gets no answer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            exp_seq_q  <= 1'b0;
            data_q     <= '0;
            seq_q      <= 1'b0;
            par_q      <= 1'b0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            resp_seq_q <= 1'b0;
            err_q      <= '0;
`ifdef ARQ_RX_STATS_EN
            dup_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            exp_seq_q  <= exp_seq_d;
            data_q     <= data_d;
            seq_q      <= seq_d;
            par_q      <= par_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            resp_seq_q <= resp_seq_d;
            err_q      <= err_d;
`ifdef ARQ_RX_STATS_EN
            dup_q      <= dup_d;
`endif
        end
    end

    // The decision in CHECK uses full_o as it is before the edge. A pop in
    // that same cycle therefore cannot turn a flow-control nack into an ack.
    // The duplicate test comes before the full test, so a duplicate is
    // acked even when the FIFO is full.
    always_comb begin
        state_d    = state_q;
        exp_seq_d  = exp_seq_q;
        data_d     = data_q;
        seq_d      = seq_q;
        par_d      = par_q;
        ack_d      = 1'b0;
        nack_d     = 1'b0;
        resp_seq_d = resp_seq_q;
        err_d      = err_q;
`ifdef ARQ_RX_STATS_EN
        dup_d      = dup_q;
`endif
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (link.frame_valid) begin
                    data_d  = link.frame_data;
                    seq_d   = link.frame_seq;
                    par_d   = link.frame_parity;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d    = RESP;
                resp_seq_d = seq_q;
                if (!parity_ok) begin
                    nack_d = 1'b1;
                    if (err_q != CNT_MAX) begin
                        err_d = err_q + ERR_CNT_WIDTH'(1);
                    end
                end else if (seq_q != exp_seq_q) begin
                    ack_d = 1'b1;
`ifdef ARQ_RX_STATS_EN
                    if (dup_q != CNT_MAX) begin
                        dup_d = dup_q + ERR_CNT_WIDTH'(1);
                    end
`endif
                end else if (full_o) begin
                    nack_d = 1'b1;
                end else begin
                    ack_d     = 1'b1;
                    push      = 1'b1;
                    exp_seq_d = ~exp_seq_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    arq_rx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (rd_en_i),
        .data_i  (data_q),
        .data_o  (data_out_o),
        .empty_o (empty_o),
        .full_o  (full_o)
    );

endmodule

// File: doc/arq_rx_fsm.md
Name: arq_rx_fsm

Overview:
Receiver end of the stop-and-wait ARQ link that the FIFO-backed tx_fsm drives. It accepts one frame at a time (data, alternating sequence bit, even parity) and checks integrity and sequence. It returns a one-cycle ack or nack, drops duplicates, and delivers in-order data to a small receive FIFO that a downstream consumer drains with rd_en.

Parameters:
DATA_WIDTH, 4, payload width per frame (matches tx data_in width)
FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2
ERR_CNT_WIDTH, 4, width of saturating parity-error counter

Ports:
clk  in  1  single system clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
frame_valid  in  1  frame present this cycle; sampled only in IDLE
frame_data  in  DATA_WIDTH  frame payload
frame_seq  in  1  alternating-bit sequence number
frame_parity  in  1  even parity: XOR of {frame_data, frame_seq, frame_parity} must be 0
rd_en  in  1  consumer pop request
ack  out  1  one-cycle positive response
nack  out  1  one-cycle negative response
resp_seq  out  1  sequence bit the ack/nack refers to
rx_busy  out  1  high whenever FSM not in IDLE
data_out  out  DATA_WIDTH  FIFO head, first-word-fall-through; 0 when empty
empty  out  1  FIFO empty
full  out  1  FIFO full
err_count  out  ERR_CNT_WIDTH  saturating count of parity nacks

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE, expected_seq=0, FIFO pointers/count=0, memory cleared. ack, nack, resp_seq, err_count, data_out all 0; rx_busy=0; empty=1, full=0. Applies in any state, including mid-CHECK/RESP; no ack/nack is emitted for the aborted frame.
- FSM: IDLE -> CHECK when frame_valid is sampled high; frame_data/seq/parity are captured into registers at that edge. CHECK -> RESP unconditionally; the decision is registered at this edge. RESP -> IDLE unconditionally.
- Latency: frame sampled at edge E0; ack or nack is high for exactly the cycle E1..E2; IDLE again after E2. Minimum frame spacing is 3 cycles.
- frame_valid while rx_busy=1 is ignored. No capture, no side effects.
- Decision in CHECK, using registered frame and the full flag as of the CHECK cycle:
  - parity bad -> nack, resp_seq=frame_seq, err_count+1 (saturate at all-ones), expected_seq unchanged, no push.
  - parity ok, seq==expected_seq, !full -> push data, toggle expected_seq, ack, resp_seq=frame_seq.
  - parity ok, seq!=expected_seq (duplicate after a lost ack) -> ack, resp_seq=frame_seq, no push, no toggle.
  - parity ok, new seq, full -> nack (flow control), err_count unchanged, no toggle.
- ack and nack are never high together.
- FIFO behaviour:
  - Pop occurs when rd_en && !empty; rd_en on empty is ignored.
  - Push and pop on the same edge are both performed and the count is unchanged.
  - A pop in the CHECK cycle does not rescue a full-nack; the full flag is sampled before the edge.
  - Pointers are clog2(FIFO_DEPTH) bits and wrap naturally; count is clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
ARQ_RX_STATS_EN: when defined, adds output dup_count [ERR_CNT_WIDTH-1:0], a saturating count of duplicate frames acked. It resets to 0. When undefined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package arq_pkg: state typedef (IDLE, CHECK, RESP); function computing even parity over {data, seq}; localparam for DATA_WIDTH default shared with tx_fsm.
- Sub-module arq_rx_fifo: synchronous FWFT FIFO with push/pop/empty/full/data_out, parameterised by width and depth. The FSM owns only the sequencing and response logic.

Test Plan:
1. Reset, then send data=4'hA, seq=0, parity=0 -> ack high on 2nd cycle after the sample edge; resp_seq=0; empty=0; data_out=4'hA.
2. Repeat the same frame (seq=0) -> ack, resp_seq=0; FIFO count unchanged; expected_seq stays 1.
3. Send data=4'h3, seq=1, parity=0 (bad) -> nack, err_count=1. Resend with parity=1 -> ack; data_out still 4'hA (head); count=2.
4. Fill FIFO to 4 entries with no reads. A 5th new frame -> nack, full=1, err_count unchanged. Pulse rd_en once, resend -> ack, full=1 again.
5. Assert frame_valid during CHECK and RESP -> no extra ack/nack and no capture. Separately, assert rst_n=0 during CHECK -> ack/nack stay 0, empty=1, next seq=0 frame is accepted.
6. Drive 20 parity-bad frames -> err_count saturates at 4'hF. With ARQ_RX_STATS_EN, 3 duplicates -> dup_count=3.
